// File: rtl/up_down_count_pkg.sv
// Shared types for the up/down counter decoder: FSM states and step classes.
package up_down_count_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational step classifier: (prev, q) -> step code and wrap flag.
module count_step_classifier
    import up_down_count_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_q,
    output logic [1:0]       o_step,
    output logic             o_wrap
);

    logic [WIDTH-1:0] w_delta;

    assign w_delta = i_q - i_prev;

    // UP is tested before DOWN so that WIDTH=1 (where +1 == -1) classifies as UP
    always_comb begin
        o_wrap = 1'b0;
        if (w_delta == '0) begin
            o_step = STEP_HOLD;
        end else if (w_delta == WIDTH'(1)) begin
            o_step = STEP_UP;
            o_wrap = (i_prev == '1);
        end else if (w_delta == '1) begin
            o_step = STEP_DOWN;
            o_wrap = (i_prev == '0);
        end else begin
            o_step = STEP_BAD;
        end
    end

endmodule

// File: rtl/up_down_count_decoder.sv
// Monitor-side decoder for an up/down counter Q bus: direction, lock, stall,
// wrap, reset and illegal-jump detection. All outputs registered.
module up_down_count_decoder
    import up_down_count_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_LEN = 2,
    parameter int unsigned ERR_W    = 8
)
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Q_in,
    output logic             Dir_up,
    output logic             Locked,
    output logic             Stalled,
    output logic             Wrap_pulse,
    output logic             Dir_change,
    output logic             Reset_seen,
    output logic             Step_err,
    output logic [ERR_W-1:0] Err_count
);

    localparam int unsigned      RUN_W   = $clog2(LOCK_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_LEN);

    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_prev, w_prev;
    logic [RUN_W-1:0] r_run, w_run, w_run_inc;
    logic [ERR_W-1:0] r_err, w_err;
    logic             r_dir, w_dir, r_locked, w_locked, r_stalled, w_stalled;
    logic             r_wrap, w_wrap, r_dchg, w_dchg, r_rseen, w_rseen, r_serr, w_serr;
    logic [1:0]       w_step_code;
    step_t            w_step;
    logic             w_step_wrap, w_legal, w_new_dir;

    count_step_classifier #(.WIDTH(WIDTH)) u_classifier (
        .i_prev (r_prev),
        .i_q    (Q_in),
        .o_step (w_step_code),
        .o_wrap (w_step_wrap)
    );

    assign w_step    = step_t'(w_step_code);
    assign w_legal   = (w_step == STEP_UP) || (w_step == STEP_DOWN);
    assign w_new_dir = (w_step == STEP_UP);
    assign w_run_inc = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 1'b1;

    always_ff @(posedge Clock) begin
        if (!Reset) r_state <= EMPTY;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (Valid) begin
            if (r_state == EMPTY) begin
                w_next_state = ACQ;
            end else if (w_legal) begin
                if (w_run_inc == RUN_MAX) w_next_state = TRACK;
            end else if (w_step == STEP_BAD) begin
                w_next_state = ACQ;
            end
        end
    end

    always_comb begin
        w_prev    = r_prev;
        w_run     = r_run;
        w_err     = r_err;
        w_dir     = r_dir;
        w_locked  = r_locked;
        w_stalled = r_stalled;
        w_wrap    = 1'b0;
        w_dchg    = 1'b0;
        w_rseen   = 1'b0;
        w_serr    = 1'b0;
        if (Valid) begin
            w_prev = Q_in;
            if (r_state != EMPTY) begin
                case (w_step)
                    STEP_HOLD: w_stalled = 1'b1;
                    STEP_UP, STEP_DOWN: begin
                        w_stalled = 1'b0;
                        w_run     = w_run_inc;
                        w_locked  = (w_run_inc == RUN_MAX);
                        w_wrap    = w_step_wrap;
                        w_dchg    = (r_state == TRACK) && (w_new_dir != r_dir);
                        w_dir     = w_new_dir;
                    end
                    default: begin
                        w_stalled = 1'b0;
                        w_run     = '0;
                        w_locked  = 1'b0;
                        if (Q_in == '0) begin
                            w_rseen = 1'b1;
                        end else begin
                            w_serr = 1'b1;
                            if (r_err != '1) w_err = r_err + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_prev    <= '0;
            r_run     <= '0;
            r_err     <= '0;
            r_dir     <= 1'b1;
            r_locked  <= 1'b0;
            r_stalled <= 1'b0;
            r_wrap    <= 1'b0;
            r_dchg    <= 1'b0;
            r_rseen   <= 1'b0;
            r_serr    <= 1'b0;
        end else begin
            r_prev    <= w_prev;
            r_run     <= w_run;
            r_err     <= w_err;
            r_dir     <= w_dir;
            r_locked  <= w_locked;
            r_stalled <= w_stalled;
            r_wrap    <= w_wrap;
            r_dchg    <= w_dchg;
            r_rseen   <= w_rseen;
            r_serr    <= w_serr;
        end
    end

    assign Dir_up     = r_dir;
    assign Locked     = r_locked;
    assign Stalled    = r_stalled;
    assign Wrap_pulse = r_wrap;
    assign Dir_change = r_dchg;
    assign Reset_seen = r_rseen;
    assign Step_err   = r_serr;
    assign Err_count  = r_err;

endmodule
